// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RISC-V control sequencer: opcodes,
// FSM states, ALU operation classes and datapath select codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_U   = 7'h37;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_B   = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6f;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_HALT      = 4'd10,
    S_JAL       = 4'd11
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_IMM   = 3'b001;
  localparam logic [2:0] ALU_LUI   = 3'b010;
  localparam logic [2:0] ALU_BR    = 3'b011;
  localparam logic [2:0] ALU_JAL   = 3'b100;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALU   = 2'b00;
  localparam logic [1:0] M2R_MEM   = 2'b01;
  localparam logic [1:0] M2R_PC4   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface multicycle_control_if;
  logic [6:0] OP_i;
  logic       Mem_Ready_i;
  logic       PC_Write_o;
  logic       IR_Write_o;
  logic       IorD_o;
  logic       Mem_Read_o;
  logic       Mem_Write_o;
  logic       ALU_Src_A_o;
  logic [1:0] ALU_Src_B_o;
  logic [2:0] ALU_Op_o;
  logic       PC_Src_o;
  logic       Branch_o;
  logic       Reg_Write_o;
  logic [1:0] Mem_to_Reg_o;
  logic       Illegal_o;

  modport master (
    input  OP_i, Mem_Ready_i,
    output PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o, Mem_Write_o,
           ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, PC_Src_o, Branch_o,
           Reg_Write_o, Mem_to_Reg_o, Illegal_o
  );

  modport slave (
    output OP_i, Mem_Ready_i,
    input  PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o, Mem_Write_o,
           ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, PC_Src_o, Branch_o,
           Reg_Write_o, Mem_to_Reg_o, Illegal_o
  );
endinterface

// File: rtl/multicycle_control_retire_counter.sv
// Wrapping retired-instruction counter with async active-low clear.
module retire_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer. Build with BRANCH_JUMP_EN to add the
// BRANCH/JAL states; otherwise B and JAL opcodes decode as illegal (HALT).
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int RETIRE_CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        ctrl,
  output logic [RETIRE_CNT_WIDTH-1:0] Retire_Count_o
);
  state_e state_q, state_d;
  logic   retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    retire            = 1'b0;
    ctrl.PC_Write_o   = 1'b0;
    ctrl.IR_Write_o   = 1'b0;
    ctrl.IorD_o       = 1'b0;
    ctrl.Mem_Read_o   = 1'b0;
    ctrl.Mem_Write_o  = 1'b0;
    ctrl.ALU_Src_A_o  = 1'b0;
    ctrl.ALU_Src_B_o  = SRCB_RS2;
    ctrl.ALU_Op_o     = ALU_ADD;
    ctrl.Reg_Write_o  = 1'b0;
    ctrl.Mem_to_Reg_o = M2R_ALU;
    ctrl.Illegal_o    = 1'b0;
`ifdef BRANCH_JUMP_EN
    ctrl.PC_Src_o     = 1'b0;
    ctrl.Branch_o     = 1'b0;
`endif
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        ctrl.Mem_Read_o  = 1'b1;
        ctrl.ALU_Src_B_o = SRCB_FOUR;
        ctrl.PC_Write_o  = ctrl.Mem_Ready_i;
        ctrl.IR_Write_o  = ctrl.Mem_Ready_i;
        if (ctrl.Mem_Ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute branch target into ALU-out while decoding
        ctrl.ALU_Src_B_o = SRCB_IMM;
        case (ctrl.OP_i)
          OP_R, OP_I, OP_U: state_d = S_EXECUTE;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
`ifdef BRANCH_JUMP_EN
          OP_B:             state_d = S_BRANCH;
          OP_JAL:           state_d = S_JAL;
`endif
          default:          state_d = S_HALT;
        endcase
      end
      S_EXECUTE: begin
        ctrl.ALU_Src_A_o = 1'b1;
        ctrl.ALU_Src_B_o = (ctrl.OP_i == OP_R) ? SRCB_RS2 : SRCB_IMM;
        case (ctrl.OP_i)
          OP_I:    ctrl.ALU_Op_o = ALU_IMM;
          OP_U:    ctrl.ALU_Op_o = ALU_LUI;
          default: ctrl.ALU_Op_o = ALU_ADD;
        endcase
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.Reg_Write_o = 1'b1;
        retire           = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.ALU_Src_A_o = 1'b1;
        ctrl.ALU_Src_B_o = SRCB_IMM;
        ctrl.ALU_Op_o    = ALU_IMM;
        state_d = (ctrl.OP_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctrl.IorD_o     = 1'b1;
        ctrl.Mem_Read_o = 1'b1;
        if (ctrl.Mem_Ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.Reg_Write_o  = 1'b1;
        ctrl.Mem_to_Reg_o = M2R_MEM;
        retire            = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl.IorD_o      = 1'b1;
        ctrl.Mem_Write_o = 1'b1;
        if (ctrl.Mem_Ready_i) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
`ifdef BRANCH_JUMP_EN
      S_BRANCH: begin
        ctrl.ALU_Src_A_o = 1'b1;
        ctrl.ALU_Op_o    = ALU_BR;
        ctrl.Branch_o    = 1'b1;
        ctrl.PC_Src_o    = 1'b1;
        retire           = 1'b1;
        state_d          = S_FETCH;
      end
      S_JAL: begin
        ctrl.PC_Write_o   = 1'b1;
        ctrl.PC_Src_o     = 1'b1;
        ctrl.Reg_Write_o  = 1'b1;
        ctrl.Mem_to_Reg_o = M2R_PC4;
        ctrl.ALU_Op_o     = ALU_JAL;
        retire            = 1'b1;
        state_d           = S_FETCH;
      end
`endif
      S_HALT:  ctrl.Illegal_o = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

`ifndef BRANCH_JUMP_EN
  assign ctrl.PC_Src_o = 1'b0;
  assign ctrl.Branch_o = 1'b0;
`endif

  retire_counter #(.WIDTH(RETIRE_CNT_WIDTH)) u_retire (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (retire),
    .count_o (Retire_Count_o)
  );
endmodule

// File: tb/tb_multicycle_control.sv
// Random instruction stream against a per-instruction-class timing model.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  localparam int W = 4;
  localparam int C_R = 0, C_I = 1, C_U = 2, C_LW = 3, C_SW = 4, C_B = 5, C_J = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus ();
  logic [W-1:0] cnt;

  multicycle_control #(.RETIRE_CNT_WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl           (bus),
    .Retire_Count_o (cnt)
  );

  logic [16:0] ov;
  assign ov = {bus.PC_Write_o, bus.IR_Write_o, bus.IorD_o, bus.Mem_Read_o,
               bus.Mem_Write_o, bus.ALU_Src_A_o, bus.ALU_Src_B_o, bus.ALU_Op_o,
               bus.PC_Src_o, bus.Branch_o, bus.Reg_Write_o, bus.Mem_to_Reg_o,
               bus.Illegal_o};

  int vectors = 0;
  int errs    = 0;
  int model_cnt = 0;

  function automatic logic [16:0] ev(input bit pcw, irw, iord, mr, mwr, sa,
                                     input logic [1:0] sb, input logic [2:0] ao,
                                     input bit ps, br, rw, input logic [1:0] m2r,
                                     input bit ill);
    return {pcw, irw, iord, mr, mwr, sa, sb, ao, ps, br, rw, m2r, ill};
  endfunction

  function automatic logic [6:0] op_of(input int c);
    case (c)
      C_R: return OP_R;   C_I: return OP_I;  C_U: return OP_U;
      C_LW: return OP_LW; C_SW: return OP_SW; C_B: return OP_B;
      default: return OP_JAL;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1 chk("rst_outs", 32'(ov), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("init_outs", 32'(ov), 32'd0);
  endtask

  // One instruction from its FETCH; fw fetch wait cycles, mw memory wait cycles.
  task automatic run_instr(input int c, input int fw, input int mw, input int abort_at);
    logic [6:0]  op;
    logic [16:0] e;
    bit          mem;
    int          lat, ms, ph;
    op  = op_of(c);
    mem = (c == C_LW) || (c == C_SW);
    lat = ((c <= C_U) ? 4 : (c == C_LW) ? 5 : (c == C_SW) ? 4 : 3) + fw + (mem ? mw : 0);
    ms  = fw + 3;
    for (int k = 0; k < lat; k++) begin
      @(posedge clk); #1;
      bus.OP_i = op;
      if (k < fw) bus.Mem_Ready_i = 1'b0;
      else if (k == fw) bus.Mem_Ready_i = 1'b1;
      else if (mem && k >= ms && k < ms + mw) bus.Mem_Ready_i = 1'b0;
      else if (mem && k == ms + mw) bus.Mem_Ready_i = 1'b1;
      else bus.Mem_Ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (k == 0) chk("retire_cnt", 32'(cnt), 32'(model_cnt));
      ph = k - fw - 2;
      if (k <= fw) e = ev(k == fw, k == fw, 0, 1, 0, 0, 2'b01, 3'b000, 0, 0, 0, 2'b00, 0);
      else if (k == fw + 1) e = ev(0, 0, 0, 0, 0, 0, 2'b10, 3'b000, 0, 0, 0, 2'b00, 0);
      else if (c <= C_U)
        e = (ph == 0) ? ev(0, 0, 0, 0, 0, 1, (c == C_R) ? 2'b00 : 2'b10, 3'(c), 0, 0, 0, 2'b00, 0)
                      : ev(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 1, 2'b00, 0);
      else if (mem) begin
        if (ph == 0) e = ev(0, 0, 0, 0, 0, 1, 2'b10, 3'b001, 0, 0, 0, 2'b00, 0);
        else if (k <= ms + mw) e = ev(0, 0, 1, c == C_LW, c == C_SW, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0);
        else e = ev(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 1, 2'b01, 0);
      end
      else if (c == C_B) e = ev(0, 0, 0, 0, 0, 1, 2'b00, 3'b011, 1, 1, 0, 2'b00, 0);
      else e = ev(1, 0, 0, 0, 0, 0, 2'b00, 3'b100, 1, 0, 1, 2'b10, 0);
      chk($sformatf("op%02h_k%0d", op, k), 32'(e), 32'(ov));
      if (k == abort_at) begin
        do_reset();
        return;
      end
    end
    model_cnt = (model_cnt + 1) % (1 << W);
  endtask

  task automatic run_halt(input logic [6:0] op);
    logic [16:0] e;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      bus.OP_i = op;
      bus.Mem_Ready_i = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (k == 0) e = ev(1, 1, 0, 1, 0, 0, 2'b01, 3'b000, 0, 0, 0, 2'b00, 0);
      else if (k == 1) e = ev(0, 0, 0, 0, 0, 0, 2'b10, 3'b000, 0, 0, 0, 2'b00, 0);
      else e = ev(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 1);
      chk($sformatf("halt%02h_k%0d", op, k), 32'(ov), 32'(e));
      if (k >= 2) chk("halt_cnt", 32'(cnt), 32'(model_cnt));
    end
    do_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.OP_i = 7'h00;
    bus.Mem_Ready_i = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(ov), 32'd0);
    chk("reset_cnt", 32'(cnt), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("init_outs", 32'(ov), 32'd0);

    run_instr(C_R, 0, 0, -1);
    run_instr(C_LW, 0, 2, -1);
`ifdef BRANCH_JUMP_EN
    n = 7;
    run_instr(C_B, 0, 0, -1);
    run_instr(C_J, 0, 0, -1);
`else
    n = 5;
`endif
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, n - 1), $urandom_range(0, 2), $urandom_range(0, 3), -1);
    while (model_cnt != (1 << W) - 1) run_instr(C_R, 0, 0, -1);
    run_instr(C_SW, 0, 1, -1);
    run_instr(C_I, 1, 0, -1);
    run_halt(7'h7f);
`ifndef BRANCH_JUMP_EN
    run_halt(OP_B);
    run_halt(OP_JAL);
`endif
    run_instr(C_U, 0, 0, -1);
    run_instr(C_LW, 0, 3, 4);
    run_instr(C_SW, 1, 0, -1);
    @(posedge clk); #1;
    bus.Mem_Ready_i = 1'b0;
    @(negedge clk);
    chk("final_cnt", 32'(cnt), 32'(model_cnt));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
